// File: rtl/rgb_layer_mixer.sv
// rgb_layer_mixer: two-stage pixel colour pipeline.
// Stage 1 resolves layer priority (lowest index wins, else background).
// Stage 2 scales each channel by the global brightness level (0..16).
// A frame-synchronous FSM fades the brightness in or out, stepping the
// level only on the rising edge of the (0,0) origin condition.
module rgb_layer_mixer #(
  parameter int WIDTH           = 640,
  parameter int HEIGHT          = 480,
  parameter int LAYERS          = 4,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic                      clk_25,
  input  logic                      reset,
  input  logic [$clog2(WIDTH)-1:0]  pxl_x,
  input  logic [$clog2(HEIGHT)-1:0] pxl_y,
  input  logic [LAYERS-1:0]         layer_draw,
  input  logic [12*LAYERS-1:0]      layer_rgb,
  input  logic [11:0]               bg_rgb,
  input  logic                      fade_req,
  input  logic                      fade_dir,
  output logic [3:0]                Red_level,
  output logic [3:0]                Green_level,
  output logic [3:0]                Blue_level,
  output logic [4:0]                fade_level,
  output logic                      fade_busy,
  output logic                      fade_done
);

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {
    IDLE_ON  = 2'd0,
    IDLE_OFF = 2'd1,
    FADE_OUT = 2'd2,
    FADE_IN  = 2'd3
  } state_t;

  state_t          state_q;
  logic [4:0]      fade_level_q;
  logic [CW-1:0]   cnt_q;
  logic            fade_busy_q;
  logic            fade_done_q;
  logic            origin_q;
  logic            origin;
  logic            frame_tick;
  logic            fading;

  logic [11:0]     sel_d;
  logic [11:0]     sel_q;
  logic [3:0]      red_q;
  logic [3:0]      green_q;
  logic [3:0]      blue_q;
  logic [8:0]      prod_r;
  logic [8:0]      prod_g;
  logic [8:0]      prod_b;

  // Frame tick: first cycle of the (0,0) origin, a held origin counts once
  always_comb begin
    origin     = (pxl_x == '0) && (pxl_y == '0);
    frame_tick = origin && !origin_q;
    fading     = (state_q == FADE_OUT) || (state_q == FADE_IN);
  end

  // Priority resolve: lowest-index drawing layer, background otherwise
  always_comb begin
    logic found;
    sel_d = bg_rgb;
    found = 1'b0;
    for (int unsigned i = 0; i < LAYERS; i++) begin
      if (layer_draw[i] && !found) begin
        sel_d = layer_rgb[12*i +: 12];
        found = 1'b1;
      end
    end
  end

  // Brightness scaling: 9-bit product per channel, keep bits [7:4]
  always_comb begin
    prod_r = {5'b0, sel_q[11:8]} * {4'b0, fade_level_q};
    prod_g = {5'b0, sel_q[7:4]}  * {4'b0, fade_level_q};
    prod_b = {5'b0, sel_q[3:0]}  * {4'b0, fade_level_q};
  end

  // Pixel pipeline: stage 1 selection, stage 2 scaled output
  always_ff @(posedge clk_25) begin
    if (reset) begin
      sel_q   <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      sel_q   <= sel_d;
      red_q   <= prod_r[7:4];
      green_q <= prod_g[7:4];
      blue_q  <= prod_b[7:4];
    end
  end

  // Fade FSM: accepted requests take precedence over a coincident frame tick
  always_ff @(posedge clk_25) begin
    if (reset) begin
      state_q      <= IDLE_ON;
      fade_level_q <= 5'd16;
      cnt_q        <= '0;
      fade_busy_q  <= 1'b0;
      fade_done_q  <= 1'b0;
      origin_q     <= 1'b0;
    end else begin
      origin_q    <= origin;
      fade_done_q <= 1'b0;
      if (fade_req && !fade_dir && (state_q != IDLE_OFF)) begin
        state_q     <= FADE_OUT;
        cnt_q       <= '0;
        fade_busy_q <= 1'b1;
      end else if (fade_req && fade_dir && (state_q != IDLE_ON)) begin
        state_q     <= FADE_IN;
        cnt_q       <= '0;
        fade_busy_q <= 1'b1;
      end else if (frame_tick && fading) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
          if (state_q == FADE_OUT) begin
            // Clamped at 0 so a reversal from an empty fade-in cannot wrap
            if (fade_level_q <= 5'd1) begin
              fade_level_q <= 5'd0;
              state_q      <= IDLE_OFF;
              fade_busy_q  <= 1'b0;
              fade_done_q  <= 1'b1;
            end else begin
              fade_level_q <= fade_level_q - 5'd1;
            end
          end else begin
            if (fade_level_q >= 5'd15) begin
              fade_level_q <= 5'd16;
              state_q      <= IDLE_ON;
              fade_busy_q  <= 1'b0;
              fade_done_q  <= 1'b1;
            end else begin
              fade_level_q <= fade_level_q + 5'd1;
            end
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign Red_level   = red_q;
  assign Green_level = green_q;
  assign Blue_level  = blue_q;
  assign fade_level  = fade_level_q;
  assign fade_busy   = fade_busy_q;
  assign fade_done   = fade_done_q;

endmodule

// File: tb/tb_rgb_layer_mixer.sv
// tb_rgb_layer_mixer: directed bench driving two mixers in parallel,
// one stepping every frame and one stepping every second frame.
module tb_rgb_layer_mixer;

  logic        clk_25 = 1'b0;
  logic        reset;
  logic [9:0]  pxl_x;
  logic [8:0]  pxl_y;
  logic [3:0]  layer_draw;
  logic [47:0] layer_rgb;
  logic [11:0] bg_rgb;
  logic        fade_req;
  logic        fade_dir;

  logic [3:0]  r1, g1, b1, r2, g2, b2;
  logic [4:0]  level1, level2;
  logic        busy1, busy2, done1, done2;
  logic [11:0] rgb1, rgb2;

  int checks   = 0;
  int failures = 0;

  assign rgb1 = {r1, g1, b1};
  assign rgb2 = {r2, g2, b2};

  always #5 clk_25 = ~clk_25;

  rgb_layer_mixer #(.WIDTH(640), .HEIGHT(480), .LAYERS(4), .FRAMES_PER_STEP(1)) dut1 (
    .clk_25(clk_25), .reset(reset), .pxl_x(pxl_x), .pxl_y(pxl_y),
    .layer_draw(layer_draw), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .fade_req(fade_req), .fade_dir(fade_dir),
    .Red_level(r1), .Green_level(g1), .Blue_level(b1),
    .fade_level(level1), .fade_busy(busy1), .fade_done(done1)
  );

  rgb_layer_mixer #(.WIDTH(640), .HEIGHT(480), .LAYERS(4), .FRAMES_PER_STEP(2)) dut2 (
    .clk_25(clk_25), .reset(reset), .pxl_x(pxl_x), .pxl_y(pxl_y),
    .layer_draw(layer_draw), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .fade_req(fade_req), .fade_dir(fade_dir),
    .Red_level(r2), .Green_level(g2), .Blue_level(b2),
    .fade_level(level2), .fade_busy(busy2), .fade_done(done2)
  );

  // Advance n clock edges and settle 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_25);
    #1;
  endtask

  // One frame: a non-origin cycle followed by an origin cycle (one tick)
  task automatic frame();
    pxl_x = 10'd5; pxl_y = 9'd5;
    cyc(1);
    pxl_x = '0; pxl_y = '0;
    cyc(1);
  endtask

  task automatic req(input logic dir);
    fade_req = 1'b1; fade_dir = dir;
    cyc(1);
    fade_req = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fade_req = 1'b0; fade_dir = 1'b0;
    pxl_x = 10'd5; pxl_y = 9'd5; layer_draw = '0; layer_rgb = '0;
    bg_rgb = 12'h5A3;
    cyc(3);
    checks++; if (rgb1 !== 12'h000) begin failures++; $display("FAIL reset_rgb got=%h exp=000", rgb1); end
    checks++; if (level1 !== 5'd16) begin failures++; $display("FAIL reset_level got=%0d exp=16", level1); end
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL reset_flags got busy=%b done=%b exp=0 0", busy1, done1); end
    reset = 1'b0;
    cyc(1);
    checks++; if (rgb1 !== 12'h000) begin failures++; $display("FAIL latency_1cyc got=%h exp=000", rgb1); end
    cyc(1);
    checks++; if (rgb1 !== 12'h5A3) begin failures++; $display("FAIL latency_2cyc got=%h exp=5a3", rgb1); end
  endtask

  task automatic test_priority();
    layer_rgb = {12'h0F0, 12'h456, 12'hF00, 12'h123};
    layer_draw = 4'b1010;
    cyc(1);
    checks++; if (rgb1 !== 12'h5A3) begin failures++; $display("FAIL prio_lag got=%h exp=5a3", rgb1); end
    cyc(1);
    checks++; if (rgb1 !== 12'hF00) begin failures++; $display("FAIL prio_1010 got=%h exp=f00", rgb1); end
    layer_draw = 4'b0000;
    cyc(1);
    checks++; if (rgb1 !== 12'hF00) begin failures++; $display("FAIL prio_bg_lag got=%h exp=f00", rgb1); end
    cyc(1);
    checks++; if (rgb1 !== 12'h5A3) begin failures++; $display("FAIL prio_bg got=%h exp=5a3", rgb1); end
    layer_draw = 4'b0101;
    cyc(2);
    checks++; if (rgb2 !== 12'h123) begin failures++; $display("FAIL prio_0101 got=%h exp=123", rgb2); end
    layer_draw = 4'b1000;
    cyc(2);
    checks++; if (rgb1 !== 12'h0F0) begin failures++; $display("FAIL prio_1000 got=%h exp=0f0", rgb1); end
    layer_draw = 4'b0000;
  endtask

  task automatic test_fade_out();
    apply_reset();
    bg_rgb = 12'hFFF; pxl_x = 10'd5; pxl_y = 9'd5;
    cyc(2);
    checks++; if (rgb1 !== 12'hFFF) begin failures++; $display("FAIL fo_full got=%h exp=fff", rgb1); end
    req(1'b0);
    checks++; if (busy1 !== 1'b1 || level1 !== 5'd16) begin failures++; $display("FAIL fo_start got busy=%b lvl=%0d exp=1 16", busy1, level1); end
    repeat (8) frame();
    checks++; if (level1 !== 5'd8) begin failures++; $display("FAIL fo_lvl8 got=%0d exp=8", level1); end
    cyc(2);
    checks++; if (rgb1 !== 12'h777) begin failures++; $display("FAIL fo_rgb777 got=%h exp=777", rgb1); end
    repeat (7) frame();
    checks++; if (level1 !== 5'd1 || done1 !== 1'b0) begin failures++; $display("FAIL fo_lvl1 got lvl=%0d done=%b exp=1 0", level1, done1); end
    frame();
    checks++; if (level1 !== 5'd0 || done1 !== 1'b1 || busy1 !== 1'b0) begin failures++; $display("FAIL fo_end got lvl=%0d done=%b busy=%b exp=0 1 0", level1, done1, busy1); end
    cyc(1);
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL fo_done_pulse got=%b exp=0", done1); end
    cyc(1);
    checks++; if (rgb1 !== 12'h000) begin failures++; $display("FAIL fo_black got=%h exp=000", rgb1); end
    checks++; if (level2 !== 5'd8) begin failures++; $display("FAIL fo_fps2_lvl got=%0d exp=8", level2); end
  endtask

  task automatic test_reversal();
    apply_reset();
    req(1'b0);
    repeat (8) frame();
    checks++; if (level2 !== 5'd12) begin failures++; $display("FAIL rev_lvl12 got=%0d exp=12", level2); end
    req(1'b1);
    checks++; if (busy2 !== 1'b1 || level2 !== 5'd12) begin failures++; $display("FAIL rev_nojump got busy=%b lvl=%0d exp=1 12", busy2, level2); end
    repeat (7) frame();
    checks++; if (level2 !== 5'd15 || busy2 !== 1'b1) begin failures++; $display("FAIL rev_lvl15 got lvl=%0d busy=%b exp=15 1", level2, busy2); end
    frame();
    checks++; if (level2 !== 5'd16 || done2 !== 1'b1 || busy2 !== 1'b0) begin failures++; $display("FAIL rev_end got lvl=%0d done=%b busy=%b exp=16 1 0", level2, done2, busy2); end
    checks++; if (level1 !== 5'd16) begin failures++; $display("FAIL rev_fps1_lvl got=%0d exp=16", level1); end
    req(1'b1);
    checks++; if (busy2 !== 1'b0 || level2 !== 5'd16) begin failures++; $display("FAIL rev_ignore got busy=%b lvl=%0d exp=0 16", busy2, level2); end
  endtask

  task automatic test_coincidence();
    apply_reset();
    pxl_x = 10'd5; pxl_y = 9'd5;
    cyc(1);
    pxl_x = '0; pxl_y = '0;
    req(1'b0);
    checks++; if (level1 !== 5'd16 || busy1 !== 1'b1) begin failures++; $display("FAIL coin_nostep got lvl=%0d busy=%b exp=16 1", level1, busy1); end
    cyc(4);
    checks++; if (level1 !== 5'd16) begin failures++; $display("FAIL coin_hold got=%0d exp=16", level1); end
    pxl_x = 10'd5; pxl_y = 9'd5;
    cyc(1);
    pxl_x = '0; pxl_y = '0;
    cyc(5);
    checks++; if (level1 !== 5'd15) begin failures++; $display("FAIL coin_held_once got=%0d exp=15", level1); end
    frame();
    checks++; if (level1 !== 5'd14) begin failures++; $display("FAIL coin_step got=%0d exp=14", level1); end
    pxl_x = 10'd5; pxl_y = 9'd5;
    cyc(1);
    pxl_x = '0; pxl_y = '0;
    req(1'b0);
    checks++; if (level1 !== 5'd14) begin failures++; $display("FAIL coin_midfade got=%0d exp=14", level1); end
    frame();
    checks++; if (level1 !== 5'd13) begin failures++; $display("FAIL coin_resume got=%0d exp=13", level1); end
  endtask

  task automatic test_reset_mid_fade();
    apply_reset();
    req(1'b0);
    repeat (11) frame();
    checks++; if (level1 !== 5'd5) begin failures++; $display("FAIL rmf_lvl5 got=%0d exp=5", level1); end
    reset = 1'b1;
    cyc(1);
    checks++; if (level1 !== 5'd16 || busy1 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL rmf_abort got lvl=%0d busy=%b done=%b exp=16 0 0", level1, busy1, done1); end
    reset = 1'b0;
    frame();
    checks++; if (level1 !== 5'd16 || done1 !== 1'b0) begin failures++; $display("FAIL rmf_after got lvl=%0d done=%b exp=16 0", level1, done1); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_fade_out();
    test_reversal();
    test_coincidence();
    test_reset_mid_fade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
